// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: FSM states, byte indices and AFE4400 SPI constants
package afe_spi_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CSS, S_SETTLE, S_LOAD, S_SHIFT, S_DONE, S_WAIT, S_HOLD} state_t;
   localparam logic [1:0] PART_ADDR = 2'd0;
   localparam logic [1:0] PART_H    = 2'd1;
   localparam logic [1:0] PART_M    = 2'd2;
   localparam logic [1:0] PART_L    = 2'd3;
   localparam logic [7:0]  AFE_CONTROL0     = 8'h00;
   localparam int          AFE_SPI_READ_BIT = 0;
   localparam logic [23:0] AFE_SPI_READ     = 24'h000001;
endpackage

// File: rtl/afe_spi_master_if.sv
// afe_spi_master_if: byte request/response bus between init sequencer and SPI master
interface afe_spi_master_if;
   logic        wr_en;
   logic        rd_en;
   logic [7:0]  tx_data;
   logic [1:0]  data_part;
   logic        spi_done;
   logic        flash;
   logic        busy;
   logic [23:0] rd_data;
   logic        rd_valid;
   modport master (output wr_en, rd_en, tx_data,
                   input  data_part, spi_done, flash, busy, rd_data, rd_valid);
   modport slave  (input  wr_en, rd_en, tx_data,
                   output data_part, spi_done, flash, busy, rd_data, rd_valid);
endinterface

// File: rtl/afe_spi_shifter.sv
// afe_spi_shifter: SCLK divider, mode-0 MSB-first byte shifter and MISO capture
module afe_spi_shifter #(
   parameter int HALF_DIV = 1
) (
   input  logic        div_clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [7:0]  tx_byte,
   input  logic        spi_miso,
   output logic        done,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic [23:0] rx_word
);
   localparam int DW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic [DW-1:0] div_cnt;
   logic          active;
   logic          half_end;
   assign half_end = div_cnt == DW'(HALF_DIV - 1);
   assign done     = active && spi_sclk && half_end && bit_cnt == 3'd7;
   assign spi_mosi = shreg[7];
   // Low half presents MOSI, rising edge captures MISO, falling edge advances to next bit
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         active   <= 1'b0;
         spi_sclk <= 1'b0;
         rx_word  <= '0;
      end else if (load) begin
         shreg    <= tx_byte;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         active   <= 1'b1;
         spi_sclk <= 1'b0;
      end else if (active) begin
         div_cnt <= half_end ? '0 : div_cnt + 1'b1;
         if (half_end && !spi_sclk) begin
            spi_sclk <= 1'b1;
            rx_word  <= {rx_word[22:0], spi_miso};
         end
         if (half_end && spi_sclk) begin
            spi_sclk <= 1'b0;
            shreg    <= {shreg[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
            active   <= !done;
         end
      end
   end
endmodule

// File: rtl/afe_spi_master.sv
// afe_spi_master: AFE4400 32-bit write / 24-bit read-back SPI frame sequencer
module afe_spi_master
   import afe_spi_pkg::*;
#(
   parameter int HALF_DIV = 1,
   parameter int CSS_CYC  = 2,
   parameter int GAP_CYC  = 4
) (
   input  logic                   div_clk,
   input  logic                   rst_n,
   afe_spi_master_if.slave        bus,
   input  logic                   spi_miso,
   output logic                   spi_sclk,
   output logic                   spi_mosi,
   output logic                   spi_cs_n
);
   state_t      state, state_d;
   logic [15:0] cnt, cnt_d;
   logic        rd_mode, rd_mode_d;
   logic [1:0]  part, part_d;
   logic [23:0] rd_q, rd_d, rx_word;
   logic        load, sh_done, valid_d, flash_d;
   logic        done_q, flash_q, valid_q, busy_q, cs_n_q;
   logic [7:0]  tx_byte;
   assign tx_byte       = (rd_mode && part != PART_ADDR) ? 8'h00 : bus.tx_data;
   assign bus.data_part = part;
   assign bus.spi_done  = done_q;
   assign bus.flash     = flash_q;
   assign bus.busy      = busy_q;
   assign bus.rd_data   = rd_q;
   assign bus.rd_valid  = valid_q;
   assign spi_cs_n      = cs_n_q;
   afe_spi_shifter #(.HALF_DIV(HALF_DIV)) u_shifter (
      .div_clk  (div_clk),
      .rst_n    (rst_n),
      .load     (load),
      .tx_byte  (tx_byte),
      .spi_miso (spi_miso),
      .done     (sh_done),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .rx_word  (rx_word)
   );
   // Next state and registered-output values; cnt restarts on every timed-state entry
   always_comb begin
      state_d   = state;
      cnt_d     = cnt + 16'd1;
      rd_mode_d = rd_mode;
      part_d    = part;
      rd_d      = rd_q;
      valid_d   = 1'b0;
      flash_d   = 1'b0;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.wr_en || bus.rd_en) begin
               state_d   = S_CSS;
               rd_mode_d = !bus.wr_en;
            end
         end
         S_CSS: if (cnt == 16'(CSS_CYC - 1)) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
         end
         S_SETTLE: if (cnt == 16'd1) state_d = S_LOAD;
         S_LOAD: begin
            load    = 1'b1;
            state_d = S_SHIFT;
         end
         S_SHIFT: if (sh_done) state_d = S_DONE;
         S_DONE: begin
            part_d  = part + 2'd1;
            cnt_d   = '0;
            state_d = part == PART_L ? S_HOLD : S_WAIT;
            if (part == PART_L && rd_mode) begin
               rd_d    = rx_word;
               valid_d = 1'b1;
            end
         end
         S_WAIT: if (bus.wr_en || rd_mode) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
         end
         S_HOLD: if (cnt == 16'(GAP_CYC - 1)) begin
            state_d = S_IDLE;
            flash_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // State and output registers; reset aborts any frame and releases cs_n at once
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rd_mode <= 1'b0;
         part    <= PART_ADDR;
         rd_q    <= '0;
         valid_q <= 1'b0;
         flash_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         cs_n_q  <= 1'b1;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         rd_mode <= rd_mode_d;
         part    <= part_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         flash_q <= flash_d;
         done_q  <= state == S_SHIFT && sh_done;
         busy_q  <= state_d != S_IDLE;
         cs_n_q  <= state_d == S_IDLE || state_d == S_HOLD;
      end
   end
endmodule

// File: tb/tb_afe_spi_master.sv
// tb_afe_spi_master: directed write/read/stall/reset/back-to-back frame tests
module tb_afe_spi_master;
   localparam int GAP = 4;
   logic        div_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_miso, spi_sclk, spi_mosi, spi_cs_n;
   afe_spi_master_if bus();
   afe_spi_master #(.HALF_DIV(1), .CSS_CYC(2), .GAP_CYC(GAP)) dut (
      .div_clk  (div_clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .spi_miso (spi_miso),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n)
   );
   always #5 div_clk = ~div_clk;
   int          n_chk = 0, n_err = 0;
   logic [31:0] frame_word = '0, miso_word = '0, mosi_sr = '0;
   int          mcnt = 0, n_rise = 0, n_done = 0, n_flash = 0, n_valid = 0;
   int          n_cs_rise = 0, n_gap_bad = 0, hi_run = 0, flash_pos = 0;
   logic [15:0] part_log = '0;
   logic [1:0]  prev_part = '0;
   logic        prev_cs = 1'b1;
   // requester model: registered byte for the current data_part
   always @(posedge div_clk) bus.tx_data <= frame_word[8*(3 - int'(bus.data_part)) +: 8];
   // AFE model: MISO bit k of the frame is presented before rising edge k
   always @(posedge spi_sclk or posedge spi_cs_n) mcnt <= spi_cs_n ? 0 : mcnt + 1;
   assign spi_miso = mcnt < 32 ? miso_word[31 - mcnt] : 1'b0;
   always @(posedge spi_sclk) begin
      mosi_sr <= {mosi_sr[30:0], spi_mosi};
      n_rise  <= n_rise + 1;
   end
   always @(negedge div_clk) begin
      if (bus.spi_done) n_done++;
      if (bus.rd_valid) n_valid++;
      if (bus.flash) begin
         n_flash++;
         flash_pos = hi_run + 1;
      end
      if (spi_cs_n && !prev_cs) n_cs_rise++;
      if (!spi_cs_n && prev_cs && hi_run < GAP) n_gap_bad++;
      hi_run  = spi_cs_n ? hi_run + 1 : 0;
      prev_cs = spi_cs_n;
      if (bus.data_part != prev_part) part_log = {part_log[13:0], bus.data_part};
      prev_part = bus.data_part;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic run_frame(input logic [31:0] w, input logic rd, input logic wr, input int stall_part);
      int   r0;
      logic fin;
      fin = 1'b0;
      frame_word = w;
      @(negedge div_clk);
      bus.wr_en = wr;
      bus.rd_en = rd;
      @(negedge div_clk);
      bus.rd_en = 1'b0;
      for (int t = 0; t < 3000 && !fin; t++) begin
         @(negedge div_clk);
         if (bus.spi_done && bus.data_part == 2'd3) bus.wr_en = 1'b0;
         if (bus.spi_done && int'(bus.data_part) == stall_part) begin
            bus.wr_en = 1'b0;
            r0 = n_rise;
            repeat (20) @(negedge div_clk);
            check("stall_sclk_edges", n_rise - r0, 0);
            check("stall_cs_n", 32'(spi_cs_n), 0);
            check("stall_busy", 32'(bus.busy), 1);
            bus.wr_en = 1'b1;
         end
         fin = bus.flash;
      end
      check("frame_flash_seen", 32'(fin), 1);
      @(posedge div_clk);
      #1;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int d0, f0, v0, c0, r0;
      logic [31:0] w;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      repeat (4) @(negedge div_clk);
      check("rst_cs_n", 32'(spi_cs_n), 1);
      check("rst_sclk", 32'(spi_sclk), 0);
      check("rst_mosi", 32'(spi_mosi), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_part", 32'(bus.data_part), 0);
      check("rst_rd_data", 32'(bus.rd_data), 0);
      check("rst_pulses", 32'({bus.spi_done, bus.flash, bus.rd_valid}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge div_clk);
      // plain write frame
      d0 = n_done; f0 = n_flash; c0 = n_cs_rise; r0 = n_rise;
      run_frame(32'h010017C0, 1'b0, 1'b1, -1);
      check("wr_mosi", mosi_sr, 32'h010017C0);
      check("wr_rise_cnt", n_rise - r0, 32);
      check("wr_done_cnt", n_done - d0, 4);
      check("wr_part_seq", 32'(part_log[7:0]), 32'h6C);
      check("wr_cs_rises", n_cs_rise - c0, 1);
      check("wr_flash_cnt", n_flash - f0, 1);
      check("wr_flash_pos", flash_pos, GAP + 1);
      check("wr_busy_after", 32'(bus.busy), 0);
      // read-back frame
      miso_word = 32'hC3123456;
      d0 = n_done; v0 = n_valid;
      run_frame(32'h2AFFFFFF, 1'b1, 1'b0, -1);
      check("rd_mosi", mosi_sr, 32'h2A000000);
      check("rd_data", 32'(bus.rd_data), 32'h123456);
      check("rd_valid_cnt", n_valid - v0, 1);
      check("rd_done_cnt", n_done - d0, 4);
      // simultaneous wr_en/rd_en: write wins
      v0 = n_valid;
      run_frame(32'h0B00ABCD, 1'b1, 1'b1, -1);
      check("both_mosi", mosi_sr, 32'h0B00ABCD);
      check("both_valid_cnt", n_valid - v0, 0);
      check("both_rd_data_hold", 32'(bus.rd_data), 32'h123456);
      // requester stall in WAIT after byte 1
      d0 = n_done;
      run_frame(32'h8E5A1F73, 1'b0, 1'b1, 1);
      check("stall_mosi", mosi_sr, 32'h8E5A1F73);
      check("stall_done_cnt", n_done - d0, 4);
      // async reset mid-bit in byte 2
      frame_word = 32'h47A5C33C;
      d0 = n_done; f0 = n_flash;
      @(negedge div_clk);
      bus.wr_en = 1'b1;
      for (int t = 0; t < 500 && !(bus.data_part == 2'd2 && spi_sclk); t++) @(negedge div_clk);
      check("abort_reached_byte2", 32'({bus.data_part, spi_sclk}), 32'b101);
      #2 rst_n = 1'b0;
      #1;
      check("abort_cs_n", 32'(spi_cs_n), 1);
      check("abort_part", 32'(bus.data_part), 0);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_sclk", 32'(spi_sclk), 0);
      bus.wr_en = 1'b0;
      repeat (5) @(negedge div_clk);
      rst_n = 1'b1;
      repeat (3) @(negedge div_clk);
      check("abort_done_cnt", n_done - d0, 2);
      check("abort_no_flash", n_flash - f0, 0);
      run_frame(32'h5AC0FFEE, 1'b0, 1'b1, -1);
      check("post_abort_mosi", mosi_sr, 32'h5AC0FFEE);
      // back-to-back sequencer frames
      d0 = n_done; f0 = n_flash; c0 = n_gap_bad;
      for (int i = 0; i < 35; i++) begin
         w = 32'h9E3779B9 * 32'(i + 1);
         run_frame(w, 1'b0, 1'b1, -1);
         check("b2b_mosi", mosi_sr, w);
      end
      check("b2b_done_cnt", n_done - d0, 140);
      check("b2b_flash_cnt", n_flash - f0, 35);
      check("b2b_gap_short", n_gap_bad - c0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
